// File: rtl/switch_requester_rt.sv
// Egress requester: pops frame descriptors from the sideband FIFO and streams each
// frame from the ingress buffer as an AXI-Stream packet, with timeout retry/drop.
module switch_requester_rt #(
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned DEST_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH        = 11,
    parameter int unsigned TIMEOUT_CTR_WIDTH = 8,
    parameter int unsigned MAX_RETRIES       = 3,
    parameter int unsigned STAT_WIDTH        = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [TIMEOUT_CTR_WIDTH-1:0]     cfg_timeout_i,
    input  logic                             cfg_retry_en_i,
    input  logic [DEST_WIDTH+ADDR_WIDTH:0]   sideband_rdata_i,
    input  logic                             sideband_empty_i,
    output logic                             sideband_ren_o,
    input  logic [DATA_WIDTH-1:0]            frame_rdata_i,
    input  logic [ADDR_WIDTH:0]              frame_rptr_i,
    input  logic                             frame_empty_i,
    output logic                             frame_ren_o,
    output logic                             frame_rrst_o,
    output logic [ADDR_WIDTH:0]              frame_rst_rptr_o,
    output logic [DATA_WIDTH-1:0]            egress_tdata_o,
    output logic [DEST_WIDTH-1:0]            egress_tdest_o,
    output logic                             egress_tvalid_o,
    output logic                             egress_tlast_o,
    input  logic                             egress_tready_i,
    output logic [STAT_WIDTH-1:0]            stat_sent_o,
    output logic [STAT_WIDTH-1:0]            stat_dropped_o,
    output logic [STAT_WIDTH-1:0]            stat_retries_o
);

    localparam int unsigned PTR_W   = ADDR_WIDTH + 1;
    localparam int unsigned TO_W    = TIMEOUT_CTR_WIDTH;
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REWIND, S_SEND, S_TIMEOUT, S_DROP, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       start_ptr_q, start_ptr_d;
    logic [PTR_W-1:0]       end_ptr_q, end_ptr_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic [TO_W-1:0]        timeout_q, timeout_d;
    logic                   retry_en_q, retry_en_d;
    logic [RETRY_W-1:0]     retries_q, retries_d;
    logic                   beats_acc_q, beats_acc_d;
    logic [TO_W-1:0]        stall_q, stall_d;
    logic                   last_fetched_q, last_fetched_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic                   sb_ren_q, sb_ren_d;
    logic                   rrst_q, rrst_d;
    logic [PTR_W-1:0]       rst_rptr_q, rst_rptr_d;
    logic [STAT_WIDTH-1:0]  sent_q, sent_d;
    logic [STAT_WIDTH-1:0]  dropped_q, dropped_d;
    logic [STAT_WIDTH-1:0]  retry_stat_q, retry_stat_d;

    logic                   hs_c;
    logic                   fetch_c;
    logic [PTR_W-1:0]       rptr_inc_c;
    logic [PTR_W-1:0]       sb_end_c;

    assign sb_end_c   = sideband_rdata_i[DEST_WIDTH +: PTR_W];
    assign rptr_inc_c = frame_rptr_i + PTR_W'(1);
    assign hs_c       = tvalid_q & egress_tready_i;
    assign fetch_c    = (state_q == S_SEND) & ~last_fetched_q & ~frame_empty_i
                        & (~tvalid_q | egress_tready_i);

    // Next-state, datapath and statistics
    always_comb begin
        state_d        = state_q;
        start_ptr_d    = start_ptr_q;
        end_ptr_d      = end_ptr_q;
        dest_d         = dest_q;
        timeout_d      = timeout_q;
        retry_en_d     = retry_en_q;
        retries_d      = retries_q;
        beats_acc_d    = beats_acc_q;
        stall_d        = stall_q;
        last_fetched_d = last_fetched_q;
        tdata_d        = tdata_q;
        tlast_d        = tlast_q;
        tvalid_d       = tvalid_q;
        rst_rptr_d     = rst_rptr_q;
        sent_d         = sent_q;
        dropped_d      = dropped_q;
        retry_stat_d   = retry_stat_q;

        if (fetch_c) begin
            tdata_d  = frame_rdata_i;
            tlast_d  = (rptr_inc_c == end_ptr_q);
            tvalid_d = 1'b1;
            if (rptr_inc_c == end_ptr_q) last_fetched_d = 1'b1;
        end else if (hs_c) begin
            tvalid_d = 1'b0;
        end

        if ((state_q != S_SEND) || hs_c) stall_d = '0;
        else if (tvalid_q && !egress_tready_i) stall_d = stall_q + TO_W'(1);

        if (state_q != S_SEND) last_fetched_d = 1'b0;
        if ((state_q == S_SEND) && hs_c) beats_acc_d = 1'b1;

        case (state_q)
            S_IDLE: if (!sideband_empty_i) state_d = S_LOAD;
            S_LOAD: begin
                dest_d      = sideband_rdata_i[DEST_WIDTH-1:0];
                end_ptr_d   = sb_end_c;
                timeout_d   = cfg_timeout_i;
                retry_en_d  = cfg_retry_en_i;
                retries_d   = '0;
                beats_acc_d = 1'b0;
                state_d     = (sb_end_c == start_ptr_q) ? S_DROP : S_REWIND;
            end
            S_REWIND: state_d = S_SEND;
            S_SEND: begin
                if (hs_c && tlast_q) state_d = S_DONE;
                else if ((timeout_q != '0) && (stall_q == timeout_q)) state_d = S_TIMEOUT;
            end
            S_TIMEOUT: begin
                // Once a beat has left, a rewind would duplicate it downstream.
                if (retry_en_q && (retries_q < RETRY_W'(MAX_RETRIES)) && !beats_acc_q) begin
                    retries_d    = retries_q + RETRY_W'(1);
                    retry_stat_d = (retry_stat_q == '1) ? retry_stat_q : retry_stat_q + STAT_WIDTH'(1);
                    state_d      = S_REWIND;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                start_ptr_d = end_ptr_q;
                dropped_d   = (dropped_q == '1) ? dropped_q : dropped_q + STAT_WIDTH'(1);
                state_d     = S_IDLE;
            end
            S_DONE: begin
                start_ptr_d = end_ptr_q;
                sent_d      = (sent_q == '1) ? sent_q : sent_q + STAT_WIDTH'(1);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_TIMEOUT) tvalid_d = 1'b0;

        // Control pulses are registered so they coincide with the LOAD/REWIND/DROP states.
        sb_ren_d = (state_d == S_LOAD);
        rrst_d   = (state_d == S_REWIND) || (state_d == S_DROP);
        if (state_d == S_REWIND) rst_rptr_d = start_ptr_q;
        else if (state_d == S_DROP) rst_rptr_d = end_ptr_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            start_ptr_q    <= '0;
            end_ptr_q      <= '0;
            dest_q         <= '0;
            timeout_q      <= '0;
            retry_en_q     <= 1'b0;
            retries_q      <= '0;
            beats_acc_q    <= 1'b0;
            stall_q        <= '0;
            last_fetched_q <= 1'b0;
            tdata_q        <= '0;
            tlast_q        <= 1'b0;
            tvalid_q       <= 1'b0;
            sb_ren_q       <= 1'b0;
            rrst_q         <= 1'b0;
            rst_rptr_q     <= '0;
            sent_q         <= '0;
            dropped_q      <= '0;
            retry_stat_q   <= '0;
        end else begin
            state_q        <= state_d;
            start_ptr_q    <= start_ptr_d;
            end_ptr_q      <= end_ptr_d;
            dest_q         <= dest_d;
            timeout_q      <= timeout_d;
            retry_en_q     <= retry_en_d;
            retries_q      <= retries_d;
            beats_acc_q    <= beats_acc_d;
            stall_q        <= stall_d;
            last_fetched_q <= last_fetched_d;
            tdata_q        <= tdata_d;
            tlast_q        <= tlast_d;
            tvalid_q       <= tvalid_d;
            sb_ren_q       <= sb_ren_d;
            rrst_q         <= rrst_d;
            rst_rptr_q     <= rst_rptr_d;
            sent_q         <= sent_d;
            dropped_q      <= dropped_d;
            retry_stat_q   <= retry_stat_d;
        end
    end

    assign sideband_ren_o   = sb_ren_q;
    assign frame_ren_o      = fetch_c;
    assign frame_rrst_o     = rrst_q;
    assign frame_rst_rptr_o = rst_rptr_q;
    assign egress_tdata_o   = tdata_q;
    assign egress_tdest_o   = dest_q;
    assign egress_tvalid_o  = tvalid_q;
    assign egress_tlast_o   = tlast_q;
    assign stat_sent_o      = sent_q;
    assign stat_dropped_o   = dropped_q;
    assign stat_retries_o   = retry_stat_q;

endmodule

// File: tb/tb_switch_requester_rt.sv
// Directed bench for switch_requester_rt with a frame-buffer/sideband FIFO model
// and a negedge stream monitor.
module tb_switch_requester_rt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_timeout;
    logic        cfg_retry;
    logic [15:0] sb_rdata;
    logic        sb_empty, sb_ren;
    logic [15:0] frame_rdata;
    logic [11:0] rptr, wptr;
    logic        frame_empty, fren, rrst;
    logic [11:0] rst_rptr;
    logic [15:0] tdata;
    logic [3:0]  tdest;
    logic        tvalid, tlast, tready;
    logic [15:0] stat_sent, stat_dropped, stat_retries;

    always #5 clk = ~clk;

    switch_requester_rt dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_timeout_i(cfg_timeout), .cfg_retry_en_i(cfg_retry),
        .sideband_rdata_i(sb_rdata), .sideband_empty_i(sb_empty), .sideband_ren_o(sb_ren),
        .frame_rdata_i(frame_rdata), .frame_rptr_i(rptr), .frame_empty_i(frame_empty),
        .frame_ren_o(fren), .frame_rrst_o(rrst), .frame_rst_rptr_o(rst_rptr),
        .egress_tdata_o(tdata), .egress_tdest_o(tdest), .egress_tvalid_o(tvalid),
        .egress_tlast_o(tlast), .egress_tready_i(tready),
        .stat_sent_o(stat_sent), .stat_dropped_o(stat_dropped), .stat_retries_o(stat_retries)
    );

    // Frame buffer and sideband FIFO model
    logic [15:0] fmem [0:2047];
    logic [15:0] sb_mem [0:15];
    logic [3:0]  sb_rd, sb_wr;
    logic        model_clr;

    assign frame_rdata = fmem[rptr[10:0]];
    assign frame_empty = (rptr == wptr);
    assign sb_rdata    = sb_mem[sb_rd];
    assign sb_empty    = (sb_rd == sb_wr);

    always @(posedge clk) begin
        if (model_clr) begin
            rptr  <= 12'd0;
            sb_rd <= sb_wr;
        end else begin
            if (rrst) rptr <= rst_rptr;
            else if (fren) rptr <= rptr + 12'd1;
            if (sb_ren) sb_rd <= sb_rd + 4'd1;
        end
    end

    // Stream monitor: logs handshakes and rewinds, checks stability under stall
    logic [15:0] log_data [0:127];
    logic        log_last [0:127];
    logic [3:0]  log_dest [0:127];
    int          log_cyc  [0:127];
    logic [11:0] rrst_log [0:63];
    int          nbeats = 0, rrst_cnt = 0, viol = 0, cyc = 0;
    logic        chk_stable;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic        prev_l;
    logic [3:0]  prev_t;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (tvalid && tready && nbeats < 128) begin
                log_data[nbeats] <= tdata;
                log_last[nbeats] <= tlast;
                log_dest[nbeats] <= tdest;
                log_cyc[nbeats]  <= cyc;
                nbeats           <= nbeats + 1;
            end
            if (rrst && rrst_cnt < 64) begin
                rrst_log[rrst_cnt] <= rst_rptr;
                rrst_cnt           <= rrst_cnt + 1;
            end
            if (chk_stable && prev_stall &&
                !(tvalid && tdata == prev_d && tlast == prev_l && tdest == prev_t))
                viol <= viol + 1;
        end
        prev_stall <= tvalid && !tready;
        prev_d     <= tdata;
        prev_l     <= tlast;
        prev_t     <= tdest;
    end

    int tests = 0, fails = 0;
    int base, rb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int k, input logic [15:0] d,
                              input logic l, input logic [3:0] t);
        check($sformatf("%s_data%0d", tag, k), 32'(log_data[base+k]), 32'(d));
        check($sformatf("%s_last%0d", tag, k), 32'(log_last[base+k]), 32'(l));
        check($sformatf("%s_dest%0d", tag, k), 32'(log_dest[base+k]), 32'(t));
    endtask

    function automatic logic [15:0] dat(input int a);
        return 16'hA000 ^ 16'(a % 2048);
    endfunction

    function automatic int count_rrst(input int from, input logic [11:0] p);
        int n = 0;
        for (int i = from; i < rrst_cnt; i++) if (rrst_log[i] == p) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [11:0] e);
        sb_mem[sb_wr] = {e, d};
        sb_wr = sb_wr + 4'd1;
    endtask

    initial begin
        rst_n = 1'b0; tready = 1'b0; cfg_timeout = 8'd0; cfg_retry = 1'b0;
        wptr = 12'd0; sb_wr = 4'd0; model_clr = 1'b1; chk_stable = 1'b0;
        for (int i = 0; i < 2048; i++) fmem[i] = dat(i);
        for (int i = 0; i < 16; i++) sb_mem[i] = 16'd0;
        repeat (3) step();

        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_sb_ren", 32'(sb_ren), 0);
        check("rst_fren", 32'(fren), 0);
        check("rst_rrst", 32'(rrst), 0);
        check("rst_tdata", 32'(tdata), 0);
        check("rst_stats", {stat_sent, stat_dropped | stat_retries}, 0);
        model_clr = 1'b0; rst_n = 1'b1;
        step();

        // Two 4-beat frames at full throughput
        wptr = 12'd8; cfg_retry = 1'b1; tready = 1'b1; base = nbeats;
        push(4'd3, 12'd4); push(4'd9, 12'd8);
        for (int i = 0; i < 100 && stat_sent != 2; i++) step();
        check("t1_sent", 32'(stat_sent), 2);
        check("t1_beats", 32'(nbeats - base), 8);
        for (int k = 0; k < 8; k++) check_beat("t1", k, dat(k), k == 3 || k == 7, (k < 4) ? 4'd3 : 4'd9);
        check("t1_b2b", 32'(log_cyc[base+3] - log_cyc[base]), 3);

        // Random backpressure over a 10-beat frame
        tready = 1'b0; wptr = 12'd18; base = nbeats; chk_stable = 1'b1;
        push(4'd5, 12'd18);
        for (int i = 0; i < 400 && stat_sent != 3; i++) begin
            tready = 1'($urandom_range(0, 1));
            step();
        end
        chk_stable = 1'b0; tready = 1'b0;
        check("t2_sent", 32'(stat_sent), 3);
        check("t2_beats", 32'(nbeats - base), 10);
        for (int k = 0; k < 10; k++) check_beat("t2", k, dat(8 + k), k == 9, 4'd5);
        check("t2_stable", 32'(viol), 0);

        // Stalled sink: initial rewind plus three retry rewinds, then drop
        cfg_timeout = 8'd5; cfg_retry = 1'b1; wptr = 12'd22; rb = rrst_cnt; base = nbeats;
        push(4'd2, 12'd22);
        for (int i = 0; i < 300 && stat_dropped != 1; i++) step();
        check("t3_dropped", 32'(stat_dropped), 1);
        check("t3_retries", 32'(stat_retries), 3);
        check("t3_rewinds", 32'(count_rrst(rb, 12'd18)), 4);
        check("t3_drop_ptr", 32'(rrst_log[rrst_cnt-1]), 32'h16);
        check("t3_nobeats", 32'(nbeats - base), 0);
        check("t3_tvalid", 32'(tvalid), 0);

        // Timeout after two accepted beats drops without rewinding
        cfg_timeout = 8'd3; wptr = 12'd27; rb = rrst_cnt; base = nbeats; tready = 1'b1;
        push(4'd7, 12'd27);
        for (int i = 0; i < 100 && (nbeats - base) < 2; i++) step();
        tready = 1'b0;
        for (int i = 0; i < 100 && stat_dropped != 2; i++) step();
        check("t4_dropped", 32'(stat_dropped), 2);
        check("t4_retries", 32'(stat_retries), 3);
        check("t4_rewinds", 32'(count_rrst(rb, 12'd22)), 1);
        check("t4_drop_ptr", 32'(rrst_log[rrst_cnt-1]), 32'h1B);
        check("t4_beats", 32'(nbeats - base), 2);
        check_beat("t4", 0, dat(22), 1'b0, 4'd7);
        check_beat("t4", 1, dat(23), 1'b0, 4'd7);

        cfg_timeout = 8'd0; wptr = 12'd29; tready = 1'b1; base = nbeats; rb = rrst_cnt;
        push(4'd1, 12'd29);
        for (int i = 0; i < 100 && stat_sent != 4; i++) step();
        check("t4n_sent", 32'(stat_sent), 4);
        check("t4n_start", 32'(rrst_log[rb]), 32'h1B);
        check("t4n_beats", 32'(nbeats - base), 2);
        check_beat("t4n", 0, dat(27), 1'b0, 4'd1);
        check_beat("t4n", 1, dat(28), 1'b1, 4'd1);

        // Drop with retry disabled moves start_ptr to 0xFFE
        cfg_timeout = 8'd2; cfg_retry = 1'b0; tready = 1'b0; wptr = 12'd30; rb = rrst_cnt;
        push(4'd0, 12'hFFE);
        for (int i = 0; i < 100 && stat_dropped != 3; i++) step();
        check("t5_dropped", 32'(stat_dropped), 3);
        check("t5_retries", 32'(stat_retries), 3);
        check("t5_rewinds", 32'(count_rrst(rb, 12'd29)), 1);
        check("t5_drop_ptr", 32'(rrst_log[rrst_cnt-1]), 32'hFFE);

        // Frame wrapping 0xFFE -> 0x002
        cfg_timeout = 8'd0; tready = 1'b1; wptr = 12'h002; base = nbeats;
        push(4'd6, 12'h002);
        for (int i = 0; i < 100 && stat_sent != 5; i++) step();
        check("t5w_sent", 32'(stat_sent), 5);
        check("t5w_beats", 32'(nbeats - base), 4);
        check_beat("t5w", 0, dat(12'h7FE), 1'b0, 4'd6);
        check_beat("t5w", 1, dat(12'h7FF), 1'b0, 4'd6);
        check_beat("t5w", 2, dat(0), 1'b0, 4'd6);
        check_beat("t5w", 3, dat(1), 1'b1, 4'd6);

        // Zero-length descriptor
        base = nbeats; rb = rrst_cnt;
        push(4'd4, 12'h002);
        for (int i = 0; i < 100 && stat_dropped != 4; i++) step();
        check("t5z_dropped", 32'(stat_dropped), 4);
        check("t5z_nobeats", 32'(nbeats - base), 0);
        check("t5z_rrst_n", 32'(rrst_cnt - rb), 1);
        check("t5z_ptr", 32'(rrst_log[rrst_cnt-1]), 32'h002);
        check("t5z_sent", 32'(stat_sent), 5);

        // Reset in the middle of beat 2
        wptr = 12'd6; base = nbeats;
        push(4'd8, 12'd6);
        for (int i = 0; i < 100 && (nbeats - base) < 1; i++) step();
        check("t6_b2_valid", 32'(tvalid), 1);
        check("t6_b2_data", 32'(tdata), 32'(dat(3)));
        rst_n = 1'b0; model_clr = 1'b1;
        #1;
        check("t6_rst_tvalid", 32'(tvalid), 0);
        check("t6_rst_fren", 32'(fren), 0);
        step(); step();
        check("t6_rst_stats", {stat_sent, stat_dropped | stat_retries}, 0);
        model_clr = 1'b0; wptr = 12'd3; base = nbeats;
        push(4'hA, 12'd3);
        rst_n = 1'b1;
        for (int i = 0; i < 100 && stat_sent != 1; i++) step();
        check("t6_sent", 32'(stat_sent), 1);
        check("t6_beats", 32'(nbeats - base), 3);
        for (int k = 0; k < 3; k++) check_beat("t6", k, dat(k), k == 2, 4'hA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
